// File: rtl/qam_symbol_packer.sv
// qam_byte_fifo: generic first-word-fall-through register FIFO with extra-MSB pointers.
// Latency: a pushed word is visible at head_dat right after the push edge when the FIFO was empty.
// Backpressure: the caller pushes only when not full (or full with a same-cycle pop); pop is ignored while empty.
module qam_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;

    // Equal pointers mean empty; same index with differing wrap bits means full.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign do_pop   = pop && !empty;

    // Storage is left unreset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Pointer advance on accepted push and on pop of a live entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end
endmodule

// qam_symbol_packer: pairs demapped 4-bit symbols into bytes, queues them, tracks count and overflow.
// Latency: 1 cycle from the second symbol of a pair to byte_valid/byte_out.
// Backpressure: symbol input never stalls; a byte completing while full with no pop is dropped (sticky overflow).
module qam_symbol_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIRST_HIGH = 1
) (
    input  logic        symbol_clock,
    input  logic        rst,
    input  logic [3:0]  sym_in,
    input  logic        sym_valid,
    input  logic        sof,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        overflow,
    output logic [15:0] byte_count
);
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } phase_t;

    phase_t     phase;
    phase_t     phase_nxt;
    logic [3:0] hold;
    logic [3:0] hold_nxt;
    logic       push_req;
    logic [7:0] pair_dat;
    logic       pop;
    logic       push;
    logic       fifo_empty;
    logic       fifo_full;

    assign pair_dat   = (FIRST_HIGH != 0) ? {hold, sym_in} : {sym_in, hold};
    assign byte_valid = !fifo_empty;
    assign pop        = byte_valid && byte_ready;
    // A full FIFO still takes the new byte when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);

    // Pairing state register; reset discards any pending half.
    always_ff @(posedge symbol_clock or negedge rst) begin
        if (!rst) begin
            phase <= EMPTY;
            hold  <= 4'h0;
        end else begin
            phase <= phase_nxt;
            hold  <= hold_nxt;
        end
    end

    // Next pairing state; sof restarts pairing and never completes a byte.
    always_comb begin
        phase_nxt = phase;
        hold_nxt  = hold;
        push_req  = 1'b0;
        if (sof) begin
            if (sym_valid) begin
                hold_nxt  = sym_in;
                phase_nxt = HALF;
            end else begin
                phase_nxt = EMPTY;
            end
        end else if (sym_valid) begin
            case (phase)
                EMPTY: begin
                    hold_nxt  = sym_in;
                    phase_nxt = HALF;
                end
                HALF: begin
                    push_req  = 1'b1;
                    phase_nxt = EMPTY;
                end
                default: phase_nxt = EMPTY;
            endcase
        end
    end

    // Accepted-byte counter and sticky drop flag, decided on the push edge.
    always_ff @(posedge symbol_clock or negedge rst) begin
        if (!rst) begin
            byte_count <= 16'h0000;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                byte_count <= byte_count + 16'd1;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    qam_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (symbol_clock),
        .rst      (rst),
        .push     (push),
        .push_dat (pair_dat),
        .pop      (pop),
        .head_dat (byte_out),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );
endmodule

// File: tb/tb_qam_symbol_packer.sv
// Testbench for qam_symbol_packer: table-driven vectors plus directed corner sequences.
// Two instances share stimulus; the second uses the low-nibble-first pairing order.
// Outputs are sampled 1 time unit after each rising edge.
module tb_qam_symbol_packer;
    logic        clk;
    logic        rst;
    logic [3:0]  sym_in;
    logic        sym_valid;
    logic        sof;
    logic        byte_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        overflow;
    logic [15:0] byte_count;
    logic [7:0]  byte_out_lo;
    logic        byte_valid_lo;
    logic        overflow_lo;
    logic [15:0] byte_count_lo;

    int n_pass;
    int n_total;

    typedef struct {
        logic        sv;
        logic [3:0]  sym;
        logic        sf;
        logic        rdy;
        logic        exp_vld;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
        logic        exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    qam_symbol_packer #(.FIFO_DEPTH(4), .FIRST_HIGH(1)) dut (
        .symbol_clock (clk),
        .rst          (rst),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sof          (sof),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .overflow     (overflow),
        .byte_count   (byte_count)
    );

    qam_symbol_packer #(.FIFO_DEPTH(4), .FIRST_HIGH(0)) dut_lo (
        .symbol_clock (clk),
        .rst          (rst),
        .sym_in       (sym_in),
        .sym_valid    (sym_valid),
        .sof          (sof),
        .byte_out     (byte_out_lo),
        .byte_valid   (byte_valid_lo),
        .byte_ready   (byte_ready),
        .overflow     (overflow_lo),
        .byte_count   (byte_count_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic [3:0] sym, input logic sf, input logic rdy,
                       input logic exp_vld, input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                       input logic exp_ovf, input logic [15:0] exp_cnt);
        vec_t v;
        v.sv = sv; v.sym = sym; v.sf = sf; v.rdy = rdy;
        v.exp_vld = exp_vld; v.exp_hi = exp_hi; v.exp_lo = exp_lo;
        v.exp_ovf = exp_ovf; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    // Apply inputs, clock once, land 1 unit after the edge.
    task automatic drive(input logic sv, input logic [3:0] sym, input logic sf, input logic rdy);
        sym_valid  = sv;
        sym_in     = sym;
        sof        = sf;
        byte_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sym_valid  = 1'b0;
        sym_in     = 4'h0;
        sof        = 1'b0;
        byte_ready = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Basic pairing with ready high: A5, 3C (lo-first: 5A, C3)
        add(1, 4'hA, 0, 1, 0, 8'h00, 8'h00, 0, 16'd0);
        add(1, 4'h5, 0, 1, 1, 8'hA5, 8'h5A, 0, 16'd1);
        add(1, 4'h3, 0, 1, 0, 8'h00, 8'h00, 0, 16'd1);
        add(1, 4'hC, 0, 1, 1, 8'h3C, 8'hC3, 0, 16'd2);
        add(0, 4'h0, 0, 1, 0, 8'h00, 8'h00, 0, 16'd2);
        // sof with a symbol discards the pending 0x1
        add(1, 4'h1, 0, 1, 0, 8'h00, 8'h00, 0, 16'd2);
        add(1, 4'h7, 1, 1, 0, 8'h00, 8'h00, 0, 16'd2);
        add(1, 4'h8, 0, 1, 1, 8'h78, 8'h87, 0, 16'd3);
        add(0, 4'h0, 0, 1, 0, 8'h00, 8'h00, 0, 16'd3);
        // sof without a symbol discards the pending 0x2
        add(1, 4'h2, 0, 1, 0, 8'h00, 8'h00, 0, 16'd3);
        add(0, 4'h0, 1, 1, 0, 8'h00, 8'h00, 0, 16'd3);
        add(1, 4'h4, 0, 1, 0, 8'h00, 8'h00, 0, 16'd3);
        add(1, 4'h6, 0, 1, 1, 8'h46, 8'h64, 0, 16'd4);
        add(0, 4'h0, 0, 1, 0, 8'h00, 8'h00, 0, 16'd4);
        // Ready low, 10 symbols: 4 bytes stored, 0x89 dropped
        add(1, 4'h0, 0, 0, 0, 8'h00, 8'h00, 0, 16'd4);
        add(1, 4'h1, 0, 0, 1, 8'h01, 8'h10, 0, 16'd5);
        add(1, 4'h2, 0, 0, 1, 8'h01, 8'h10, 0, 16'd5);
        add(1, 4'h3, 0, 0, 1, 8'h01, 8'h10, 0, 16'd6);
        add(1, 4'h4, 0, 0, 1, 8'h01, 8'h10, 0, 16'd6);
        add(1, 4'h5, 0, 0, 1, 8'h01, 8'h10, 0, 16'd7);
        add(1, 4'h6, 0, 0, 1, 8'h01, 8'h10, 0, 16'd7);
        add(1, 4'h7, 0, 0, 1, 8'h01, 8'h10, 0, 16'd8);
        add(1, 4'h8, 0, 0, 1, 8'h01, 8'h10, 0, 16'd8);
        add(1, 4'h9, 0, 0, 1, 8'h01, 8'h10, 1, 16'd8);
        // Drain in order; overflow stays set
        add(0, 4'h0, 0, 1, 1, 8'h23, 8'h32, 1, 16'd8);
        add(0, 4'h0, 0, 1, 1, 8'h45, 8'h54, 1, 16'd8);
        add(0, 4'h0, 0, 1, 1, 8'h67, 8'h76, 1, 16'd8);
        add(0, 4'h0, 0, 1, 0, 8'h00, 8'h00, 1, 16'd8);

        sym_valid  = 1'b0;
        sym_in     = 4'h0;
        sof        = 1'b0;
        byte_ready = 1'b0;
        rst        = 1'b0;
        #2;
        check("reset_vld", {31'd0, byte_valid}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        check("reset_cnt", {16'd0, byte_count}, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sv, vecs[i].sym, vecs[i].sf, vecs[i].rdy);
            check($sformatf("v%0d_vld", i), {31'd0, byte_valid}, {31'd0, vecs[i].exp_vld});
            check($sformatf("v%0d_vld_lo", i), {31'd0, byte_valid_lo}, {31'd0, vecs[i].exp_vld});
            check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("v%0d_ovf_lo", i), {31'd0, overflow_lo}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("v%0d_cnt", i), {16'd0, byte_count}, {16'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d_cnt_lo", i), {16'd0, byte_count_lo}, {16'd0, vecs[i].exp_cnt});
            if (vecs[i].exp_vld) begin
                check($sformatf("v%0d_byte", i), {24'd0, byte_out}, {24'd0, vecs[i].exp_hi});
                check($sformatf("v%0d_byte_lo", i), {24'd0, byte_out_lo}, {24'd0, vecs[i].exp_lo});
            end
        end

        // Full FIFO, pair completes on the same edge as a pop: push accepted
        do_reset();
        for (int s = 1; s <= 8; s++) begin
            drive(1'b1, 4'(s), 1'b0, 1'b0);
        end
        check("full_head", {24'd0, byte_out}, 32'h12);
        check("full_cnt", {16'd0, byte_count}, 32'd4);
        drive(1'b1, 4'hB, 1'b0, 1'b0);
        drive(1'b1, 4'hD, 1'b0, 1'b1);
        check("fullpop_head", {24'd0, byte_out}, 32'h34);
        check("fullpop_cnt", {16'd0, byte_count}, 32'd5);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        check("fullpop_d1", {24'd0, byte_out}, 32'h56);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        check("fullpop_d2", {24'd0, byte_out}, 32'h78);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        check("fullpop_d3", {24'd0, byte_out}, 32'hBD);
        check("fullpop_d3_vld", {31'd0, byte_valid}, 32'd1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        check("fullpop_empty", {31'd0, byte_valid}, 32'd0);

        // Asynchronous reset mid-pair with 2 bytes queued
        do_reset();
        drive(1'b1, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0);
        drive(1'b1, 4'h3, 1'b0, 1'b0);
        drive(1'b1, 4'h4, 1'b0, 1'b0);
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        check("pre_arst_cnt", {16'd0, byte_count}, 32'd2);
        sym_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("arst_vld", {31'd0, byte_valid}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        check("arst_cnt", {16'd0, byte_count}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 4'hF, 1'b0, 1'b1);
        check("arst_half_gone", {31'd0, byte_valid}, 32'd0);
        drive(1'b1, 4'hE, 1'b0, 1'b1);
        check("arst_fe_vld", {31'd0, byte_valid}, 32'd1);
        check("arst_fe", {24'd0, byte_out}, 32'hFE);
        check("arst_fe_cnt", {16'd0, byte_count}, 32'd1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        check("arst_drained", {31'd0, byte_valid}, 32'd0);

        // Counter wrap: preload 0xFFFF, then one more accepted byte
        do_reset();
        force dut.byte_count = 16'hFFFF;
        #1;
        release dut.byte_count;
        drive(1'b1, 4'h1, 1'b0, 1'b1);
        check("wrap_preload", {16'd0, byte_count}, 32'hFFFF);
        drive(1'b1, 4'h2, 1'b0, 1'b1);
        check("wrap_cnt", {16'd0, byte_count}, 32'h0000);
        check("wrap_ovf", {31'd0, overflow}, 32'd0);
        check("wrap_byte", {24'd0, byte_out}, 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/qam_symbol_packer.md
# qam_symbol_packer

Downstream consumer of the 16-QAM demapper datapath. Takes one 4-bit demapped symbol per `symbol_clock` cycle, pairs consecutive symbols into bytes (first symbol in the high nibble by default), and buffers the bytes in a small first-word-fall-through FIFO with a valid/ready output handshake toward the byte sink. It also provides frame alignment, a sticky overflow flag and a running byte count.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: byte FIFO depth; power of two, ≥ 2.
- `FIRST_HIGH`, default 1: 1 places the first symbol of a pair in bits [7:4]; 0 places it in bits [3:0].

Ports:
- `symbol_clock`, input, 1: the single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sym_in`, input, 4: demapped symbol from the demapper `data_out`.
- `sym_valid`, input, 1: `sym_in` is valid this cycle.
- `sof`, input, 1: start of frame; realigns nibble pairing.
- `byte_out`, output, 8: head-of-FIFO byte.
- `byte_valid`, output, 1: FIFO is not empty.
- `byte_ready`, input, 1: the sink accepts `byte_out` this cycle.
- `overflow`, output, 1: sticky; a completed byte was dropped.
- `byte_count`, output, 16: count of bytes accepted into the FIFO, modulo 2^16.

## Operation

Nibble pairing:
- The pairing state is a 1-bit `phase` plus a 4-bit `hold` register. `phase` has two states: EMPTY (0) and HALF (1).
- EMPTY and `sym_valid`: `hold` <= `sym_in`; go to HALF.
- HALF and `sym_valid`: form the byte, request a push, return to EMPTY.
  - With `FIRST_HIGH`=1 the byte is {`hold`, `sym_in`}.
  - With `FIRST_HIGH`=0 the byte is {`sym_in`, `hold`}.
- `sym_valid` low: `phase` and `hold` keep their values. Gaps of any length are allowed between the two symbols of a pair.
- `sof` with `sym_valid`: any pending half is discarded. `sym_in` is taken as the first nibble (`hold` <= `sym_in`, go to HALF). No push occurs and no flag is set.
- `sof` without `sym_valid`: go to EMPTY and discard any pending half.

FIFO:
- Storage is a register array with `FIFO_DEPTH` entries and read/write pointers that are log2(`FIFO_DEPTH`)+1 bits wide. Full/empty are decided by comparing the pointer MSBs.
- `byte_out` = mem[rd_ptr], driven combinationally (first-word fall-through). It is don't-care while `byte_valid`=0.
- Pop when `byte_valid` & `byte_ready`.
- Push when a byte is formed and (not full, or a pop occurs in the same cycle).
- Full, no pop, and a push request: the byte is dropped, `overflow` <= 1, and `byte_count` does not increment. FIFO contents are unchanged.
- Push and pop in the same cycle while empty: the push is accepted and the pop does not happen, because `byte_valid` was 0.
- `byte_count` increments on each accepted push and wraps from 0xFFFF to 0x0000.
- `overflow` clears only on reset.

Reset (`rst`=0, asynchronous):
- `phase`=EMPTY, `hold`=0, both pointers 0.
- `byte_valid`=0, `overflow`=0, `byte_count`=0.
- `byte_out` reads mem[0]; the memory is not required to be reset.
- A reset asserted mid-pair discards the pending half.
- Reset release is synchronous to `symbol_clock` by the system.

## Timing

- The second symbol of a pair is sampled at edge N. The byte is written at edge N. With the FIFO previously empty, `byte_valid`=1 and `byte_out` is valid after edge N, i.e. during cycle N+1. Latency is 1 cycle from the second symbol to output.
- Pop at edge M: the next entry appears on `byte_out` immediately after edge M; `byte_valid` drops after edge M if the FIFO became empty.
- `byte_valid` must not depend combinationally on `byte_ready`.
- With `byte_ready` tied high, sustained throughput is 1 byte per 2 symbols with no loss.
- `byte_count` and `overflow` update on the same edge as the push decision.

## Test plan

- Reset, then `sym_valid`=1 with symbols 0xA, 0x5, 0x3, 0xC and `byte_ready`=1 → `byte_out` 0xA5 and then 0x3C, each valid for exactly one cycle, one cycle after the second nibble; `byte_count`=2. With `FIRST_HIGH`=0 the outputs are 0x5A and 0xC3.
- Symbol 0x1, then `sof` together with symbol 0x7, then symbol 0x8 → a single byte 0x78; the 0x1 is discarded; `overflow`=0.
- `byte_ready`=0 and 10 symbols 0x0..0x9 with `FIFO_DEPTH`=4 → 4 bytes are stored (0x01, 0x23, 0x45, 0x67); byte 0x89 is dropped; `overflow`=1 and stays 1; `byte_count`=4. Then `byte_ready`=1 → the 4 bytes drain in order.
- FIFO full, with a pair completing in the same cycle as `byte_ready`=1 → the push is accepted, `overflow` stays 0, and `byte_count` increments.
- Assert `rst`=0 asynchronously between the edges of a pair, with 2 bytes queued → all outputs go to 0 immediately; after release, symbols 0xF, 0xE produce only 0xFE with `byte_count`=1.
- Preload `byte_count` to 0xFFFF by pushing 65535 bytes with `byte_ready`=1, then push one more byte → `byte_count`=0x0000 and `overflow`=0.
